// File: rtl/baseball_scoreboard_mux_if.sv
`default_nettype none
//============================================================================
// Module      : baseball_scoreboard_mux_if
// Description : Bundle between the game-state logic and the scoreboard
//               output block: run/team/base inputs, LED, 7-segment and
//               score status outputs.
// Revision    : 1.0 - initial release
//============================================================================
interface baseball_scoreboard_mux_if #(
    parameter int DIGITS = 2
);
    // Game-state side
    logic                  team;
    logic [2:0]            base;
    logic [3:0]            add_to_score;
    logic                  clear_scores;

    // Board-pin side
    logic                  team0_led;
    logic                  team1_led;
    logic                  base1_led;
    logic                  base2_led;
    logic                  base3_led;
    logic [7:0]            seg_out;
    logic [2*DIGITS-1:0]   digit_sel;
    logic [4*DIGITS-1:0]   score0_bcd;
    logic [4*DIGITS-1:0]   score1_bcd;

    // Game-state logic drives events and observes the board
    modport master (
        output team, base, add_to_score, clear_scores,
        input  team0_led, team1_led, base1_led, base2_led, base3_led,
        input  seg_out, digit_sel, score0_bcd, score1_bcd
    );

    // Scoreboard block consumes events and drives the board
    modport slave (
        input  team, base, add_to_score, clear_scores,
        output team0_led, team1_led, base1_led, base2_led, base3_led,
        output seg_out, digit_sel, score0_bcd, score1_bcd
    );
endinterface
`default_nettype wire

// File: rtl/baseball_scoreboard_mux.sv
`default_nettype none
//============================================================================
// Module      : baseball_scoreboard_mux
// Description : Two-team saturating BCD run totals with edge-detected run
//               crediting, a time-multiplexed common-segment 7-segment
//               display with leading-zero blanking, and team/base LEDs.
// Revision    : 1.0 - initial release
//============================================================================
module baseball_scoreboard_mux #(
    parameter int DIGITS         = 2,
    parameter int SCAN_DIV       = 1024,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    baseball_scoreboard_mux_if.slave  bus
);

    localparam int c_NUM_DIGITS = 2 * DIGITS;
    localparam int c_IDX_W      = (c_NUM_DIGITS > 1) ? $clog2(c_NUM_DIGITS) : 1;
    localparam int c_DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_SCORE_W    = 4 * DIGITS;

    localparam logic [7:0] c_SEG_ZERO_LOW = 8'b00000011;
    localparam logic [7:0] c_SEG_BLANK_LOW = 8'b11111111;
    localparam logic [7:0] c_SEG_RESET =
        (SEG_ACTIVE_LOW != 0) ? c_SEG_ZERO_LOW : ~c_SEG_ZERO_LOW;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NUM_DIGITS - 1);

    // Registered state
    logic [c_SCORE_W-1:0]    r_score0;
    logic [c_SCORE_W-1:0]    r_score1;
    logic                    r_prev_add;
    logic [c_DIV_W-1:0]      r_div;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_NUM_DIGITS-1:0] r_digit_sel;
    logic [7:0]              r_seg;

    // Combinational helpers
    logic                    w_add_nz;
    logic                    w_fire;
    logic [2:0]              w_add_val;
    logic [c_SCORE_W-1:0]    w_target;
    logic [c_SCORE_W-1:0]    w_sum_bcd;
    logic [c_SCORE_W-1:0]    w_new_score;
    logic                    w_sat;
    logic [4:0]              w_dsum;
    logic                    w_carry;
    logic [DIGITS-1:0]       w_blankable0;
    logic [DIGITS-1:0]       w_blankable1;
    logic [3:0]              w_nibble;
    logic                    w_blank;
    logic [7:0]              w_seg_low;
    logic [7:0]              w_seg_next;
    logic                    w_load;

    // Active-low segment pattern {a,b,c,d,e,f,g,dp} for one BCD nibble
    function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'b00000011;
            4'd1:    pat = 8'b10011111;
            4'd2:    pat = 8'b00100101;
            4'd3:    pat = 8'b00001101;
            4'd4:    pat = 8'b10011001;
            4'd5:    pat = 8'b01001001;
            4'd6:    pat = 8'b01000001;
            4'd7:    pat = 8'b00011111;
            4'd8:    pat = 8'b00000001;
            4'd9:    pat = 8'b00001001;
            default: pat = 8'b10010001;
        endcase
        return pat;
    endfunction

    // A run is credited only on the first cycle of a nonzero request
    assign w_add_nz = |bus.add_to_score;
    assign w_fire   = w_add_nz & ~r_prev_add;

    // One-hot run code to run count; anything else credits nothing
    always_comb begin
        w_add_val = 3'd0;
        case (bus.add_to_score)
            4'b0001: w_add_val = 3'd1;
            4'b0010: w_add_val = 3'd2;
            4'b0100: w_add_val = 3'd3;
            4'b1000: w_add_val = 3'd4;
            default: w_add_val = 3'd0;
        endcase
    end

    assign w_target = bus.team ? r_score1 : r_score0;

    // Ripple decimal add of the run count into the LSD of the batting team
    always_comb begin
        w_sum_bcd = '0;
        w_carry   = 1'b0;
        w_dsum    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == 0) begin
                w_dsum = {1'b0, w_target[4*i +: 4]} + {2'b00, w_add_val};
            end else begin
                w_dsum = {1'b0, w_target[4*i +: 4]} + {4'b0000, w_carry};
            end
            if (w_dsum > 5'd9) begin
                w_sum_bcd[4*i +: 4] = 4'(w_dsum - 5'd10);
                w_carry             = 1'b1;
            end else begin
                w_sum_bcd[4*i +: 4] = w_dsum[3:0];
                w_carry             = 1'b0;
            end
        end
        w_sat = w_carry;
    end

    // Carry out of the MSD means the true sum overflowed: pin at all 9s
    assign w_new_score = w_sat ? {DIGITS{4'h9}} : w_sum_bcd;

    // Score registers: clear wins over a same-cycle run, which is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_score0   <= '0;
            r_score1   <= '0;
            r_prev_add <= 1'b0;
        end else begin
            r_prev_add <= w_add_nz;
            if (bus.clear_scores) begin
                r_score0 <= '0;
                r_score1 <= '0;
            end else if (w_fire && (w_add_val != 3'd0)) begin
                if (bus.team) begin
                    r_score1 <= w_new_score;
                end else begin
                    r_score0 <= w_new_score;
                end
            end
        end
    end

    // Scan timing: dwell SCAN_DIV clocks per digit, then step to the next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // A digit may be blanked when it and every more-significant digit are 0
    for (genvar j = 0; j < DIGITS; j++) begin : g_blank
        assign w_blankable0[j] = (j != 0) && !(|r_score0[c_SCORE_W-1:4*j]);
        assign w_blankable1[j] = (j != 0) && !(|r_score1[c_SCORE_W-1:4*j]);
    end

    // Pick the nibble and blank flag for the digit index being scanned
    always_comb begin
        w_nibble = 4'd0;
        w_blank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nibble = r_score0[4*i +: 4];
                w_blank  = w_blankable0[i];
            end
            if (r_idx == c_IDX_W'(DIGITS + i)) begin
                w_nibble = r_score1[4*i +: 4];
                w_blank  = w_blankable1[i];
            end
        end
    end

    assign w_seg_low  = w_blank ? c_SEG_BLANK_LOW : seg_pattern(w_nibble);
    assign w_seg_next = (SEG_ACTIVE_LOW != 0) ? w_seg_low : ~w_seg_low;

    // The display latches a new digit once, on the first dwell cycle
    assign w_load = (r_div == '0);

    // Segment bus and digit select update together, one cycle after index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit_sel <= c_NUM_DIGITS'(1);
            r_seg       <= c_SEG_RESET;
        end else if (w_load) begin
            r_digit_sel <= c_NUM_DIGITS'(1) << r_idx;
            r_seg       <= w_seg_next;
        end
    end

    // LEDs follow the game-state inputs directly; base LEDs are active-low
    assign bus.team0_led  = bus.team;
    assign bus.team1_led  = !bus.team;
    assign bus.base1_led  = !bus.base[2];
    assign bus.base2_led  = !bus.base[1];
    assign bus.base3_led  = !bus.base[0];

    assign bus.seg_out    = r_seg;
    assign bus.digit_sel  = r_digit_sel;
    assign bus.score0_bcd = r_score0;
    assign bus.score1_bcd = r_score1;

endmodule
`default_nettype wire

// File: tb/tb_baseball_scoreboard_mux.sv
`default_nettype none
//============================================================================
// Module      : tb_baseball_scoreboard_mux
// Description : Self-checking bench for baseball_scoreboard_mux. Two DUTs
//               (active-low and active-high segment bus) share stimulus
//               and are compared against an integer-score reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_baseball_scoreboard_mux;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int NDIG     = 2 * DIGITS;
    localparam int MAXV     = 99;

    logic clk = 1'b0;
    logic reset_n;
    logic       d_team;
    logic [2:0] d_base;
    logic [3:0] d_add;
    logic       d_clr;

    int n_checks = 0;
    int n_errors = 0;

    baseball_scoreboard_mux_if #(.DIGITS(DIGITS)) if_lo ();
    baseball_scoreboard_mux_if #(.DIGITS(DIGITS)) if_hi ();

    assign if_lo.team = d_team;
    assign if_lo.base = d_base;
    assign if_lo.add_to_score = d_add;
    assign if_lo.clear_scores = d_clr;
    assign if_hi.team = d_team;
    assign if_hi.base = d_base;
    assign if_hi.add_to_score = d_add;
    assign if_hi.clear_scores = d_clr;

    baseball_scoreboard_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1)) u_dut_lo (
        .clk(clk), .reset_n(reset_n), .bus(if_lo)
    );
    baseball_scoreboard_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(0)) u_dut_hi (
        .clk(clk), .reset_n(reset_n), .bus(if_hi)
    );

    always #5 clk = ~clk;

    logic [7:0] pat [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                             8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};

    // Reference model state: plain integer scores and a free-running cycle count
    int         m_score [2];
    bit         m_prev;
    int         m_cyc;
    logic [3:0] m_sel;
    logic [7:0] m_seg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int p);
        int r = 1;
        for (int k = 0; k < p; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    // Active-low pattern for digit position p of a score worth v
    function automatic logic [7:0] digit_pattern(input int v, input int p);
        if (p > 0 && v < pow10(p)) return 8'hFF;
        return pat[(v / pow10(p)) % 10];
    endfunction

    task automatic model_reset();
        m_score[0] = 0;
        m_score[1] = 0;
        m_prev = 0;
        m_cyc  = 0;
        m_sel  = 4'b0001;
        m_seg  = 8'b00000011;
    endtask

    // One clock edge of the reference model with the inputs applied this cycle
    task automatic model_edge(input logic tm, input logic [3:0] ad, input logic cl);
        int idx, val;
        bit fire;
        if (m_cyc % SCAN_DIV == 0) begin
            idx   = (m_cyc / SCAN_DIV) % NDIG;
            m_sel = 4'(1 << idx);
            m_seg = digit_pattern(m_score[idx / DIGITS], idx % DIGITS);
        end
        fire   = (ad != 0) && !m_prev;
        m_prev = (ad != 0);
        case (ad)
            4'b0001: val = 1;
            4'b0010: val = 2;
            4'b0100: val = 3;
            4'b1000: val = 4;
            default: val = 0;
        endcase
        if (cl) begin
            m_score[0] = 0;
            m_score[1] = 0;
        end else if (fire) begin
            m_score[tm] = (m_score[tm] + val > MAXV) ? MAXV : m_score[tm] + val;
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        logic [7:0] seg_inv;
        seg_inv = ~m_seg;
        check("sel_lo", if_lo.digit_sel, m_sel);
        check("seg_lo", if_lo.seg_out, m_seg);
        check("sel_hi", if_hi.digit_sel, m_sel);
        check("seg_hi", if_hi.seg_out, seg_inv);
        check("score0", if_lo.score0_bcd, to_bcd(m_score[0]));
        check("score1", if_lo.score1_bcd, to_bcd(m_score[1]));
        check("score0_hi", if_hi.score0_bcd, to_bcd(m_score[0]));
        check("score1_hi", if_hi.score1_bcd, to_bcd(m_score[1]));
    endtask

    task automatic check_leds();
        check("team0_led", if_lo.team0_led, d_team);
        check("team1_led", if_lo.team1_led, !d_team);
        check("base1_led", if_lo.base1_led, !d_base[2]);
        check("base2_led", if_lo.base2_led, !d_base[1]);
        check("base3_led", if_lo.base3_led, !d_base[0]);
    endtask

    // Apply inputs at the falling edge, clock once, compare at the next fall
    task automatic step(input logic tm, input logic [3:0] ad, input logic cl, input logic [2:0] bs);
        d_team = tm;
        d_add  = ad;
        d_clr  = cl;
        d_base = bs;
        #1;
        check_leds();
        @(posedge clk);
        model_edge(tm, ad, cl);
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input logic tm, input logic [3:0] ad);
        step(tm, ad, 1'b0, 3'b000);
        step(tm, 4'b0000, 1'b0, 3'b000);
    endtask

    initial begin
        int budget;
        logic [3:0] ra;
        reset_n = 1'b0;
        d_team = 1'b0;
        d_base = 3'b000;
        d_add  = 4'b0000;
        d_clr  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset_n = 1'b1;

        // Scan cycling with all-zero scores: two full rotations
        for (int i = 0; i < 2 * NDIG * SCAN_DIV; i++) step(1'b0, 4'b0000, 1'b0, 3'b000);

        // Held run credits once, then further pulses with decimal carry
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0100, 1'b0, 3'b000);
        step(1'b0, 4'b0000, 1'b0, 3'b000);
        check("s0_held3", if_lo.score0_bcd, 8'h03);
        pulse(1'b0, 4'b1000);
        check("s0_plus4", if_lo.score0_bcd, 8'h07);
        pulse(1'b0, 4'b0100);
        check("s0_carry", if_lo.score0_bcd, 8'h10);
        for (int i = 0; i < NDIG * SCAN_DIV + 2; i++) step(1'b0, 4'b0000, 1'b0, 3'b000);

        // Team 1 to 97, then saturation at 99
        for (int i = 0; i < 24; i++) pulse(1'b1, 4'b1000);
        pulse(1'b1, 4'b0001);
        check("s1_97", if_lo.score1_bcd, 8'h97);
        pulse(1'b1, 4'b1000);
        check("s1_sat", if_lo.score1_bcd, 8'h99);
        pulse(1'b1, 4'b0010);
        check("s1_sat_hold", if_lo.score1_bcd, 8'h99);
        check("s0_untouched", if_lo.score0_bcd, 8'h10);

        // Non-one-hot edge credits nothing; changing without release also nothing
        step(1'b0, 4'b0110, 1'b0, 3'b000);
        step(1'b0, 4'b0110, 1'b0, 3'b000);
        step(1'b0, 4'b0010, 1'b0, 3'b000);
        step(1'b0, 4'b0000, 1'b0, 3'b000);
        check("s0_no_credit", if_lo.score0_bcd, 8'h10);

        // LEDs
        step(1'b1, 4'b0000, 1'b0, 3'b101);
        check("base1_led_dir", if_lo.base1_led, 1'b0);
        check("base2_led_dir", if_lo.base2_led, 1'b1);

        // Clear wins over a simultaneous run
        step(1'b0, 4'b0001, 1'b1, 3'b000);
        step(1'b0, 4'b0000, 1'b0, 3'b000);
        check("s0_cleared", if_lo.score0_bcd, 8'h00);
        check("s1_cleared", if_lo.score1_bcd, 8'h00);

        // Randomized play
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) ra = 4'b0000;
            else if (r < 9) ra = 4'(1 << $urandom_range(0, 3));
            else ra = 4'($urandom);
            step(1'($urandom), ra, ($urandom_range(0, 59) == 0), 3'($urandom));
        end

        // Asynchronous reset in the middle of the index-2 dwell
        budget = 0;
        while (!(((m_cyc / SCAN_DIV) % NDIG == 2) && (m_cyc % SCAN_DIV == 1)) && budget < 100) begin
            step(1'b1, 4'b0000, 1'b0, 3'b000);
            budget++;
        end
        check("reach_idx2", (budget < 100), 1'b1);
        pulse(1'b1, 4'b0001);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_sel", if_lo.digit_sel, 4'b0001);
        check("rst_seg", if_lo.seg_out, 8'b00000011);
        check("rst_seg_hi", if_hi.seg_out, 8'b11111100);
        check("rst_s0", if_lo.score0_bcd, 8'h00);
        check("rst_s1", if_lo.score1_bcd, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NDIG * SCAN_DIV + 3; i++) step(1'b0, 4'b0000, 1'b0, 3'b000);
        pulse(1'b0, 4'b0010);
        for (int i = 0; i < NDIG * SCAN_DIV; i++) step(1'b0, 4'b0000, 1'b0, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
